// File: rtl/fft_frame_loader.sv
// Loads one frame of 2^AWL stream samples into the FFT working RAM, then starts the core and waits for it to release the RAM.
// Define FFT_LOADER_BITREV_EN to write samples in bit-reversed address order; otherwise natural order is used.
module fft_frame_loader #(
  parameter int IWL       = 32,
  parameter int AWL       = 5,
  parameter int START_LEN = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic [IWL-1:0] i_DATA,
  input  logic           i_VALID,
  output logic           o_READY,
  input  logic           i_FFT_BLOCK,
  output logic [AWL-1:0] o_A_ADDR,
  output logic [IWL-1:0] o_A_DATA,
  output logic           o_RAM_Wr,
  output logic           o_START,
  output logic           o_FRAME_DONE
);

  localparam int SCW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(START_LEN - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [AWL-1:0] cnt_q, cnt_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic           wr_q, wr_d;
  logic [AWL-1:0] addr_q, addr_d;
  logic [IWL-1:0] data_q, data_d;
  logic           start_q, start_d;
  logic           done_q, done_d;
  logic           ready_en;
  logic           handshake;

  function automatic logic [AWL-1:0] map_addr(input logic [AWL-1:0] c);
    logic [AWL-1:0] r;
`ifdef FFT_LOADER_BITREV_EN
    for (int b = 0; b < AWL; b++) begin
      r[b] = c[AWL-1-b];
    end
`else
    r = c;
`endif
    return r;
  endfunction

  assign ready_en  = EN & (state_q == ST_LOAD) & ~i_FFT_BLOCK;
  assign handshake = i_VALID & ready_en;

  // Registered strobes are held while EN is low and only masked at the port,
  // so a write captured just before a pause is still issued afterwards.
  assign o_READY      = ready_en & ~RST;
  assign o_RAM_Wr     = wr_q & EN;
  assign o_START      = start_q & EN;
  assign o_FRAME_DONE = done_q & EN;
  assign o_A_ADDR     = addr_q;
  assign o_A_DATA     = data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    start_d = start_q;
    done_d  = done_q;
    if (EN) begin
      wr_d   = 1'b0;
      done_d = 1'b0;
      unique case (state_q)
        ST_LOAD: begin
          if (handshake) begin
            wr_d   = 1'b1;
            addr_d = map_addr(cnt_q);
            data_d = i_DATA;
            cnt_d  = cnt_q + 1'b1;
            if (&cnt_q) begin
              state_d = ST_START;
              start_d = 1'b1;
              scnt_d  = '0;
            end
          end
        end
        ST_START: begin
          if (scnt_q == SC_LAST) begin
            state_d = ST_WAIT_ACK;
            start_d = 1'b0;
            scnt_d  = '0;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (i_FFT_BLOCK) state_d = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!i_FFT_BLOCK) begin
            state_d = ST_LOAD;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      scnt_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Upstream input stage of the iterative FFT core (`top_fft_iter`). Accepts a valid/ready stream of packed complex samples and writes one frame of 2^AWL samples into the FFT's working RAM through its external A-port (`i_A_ADDR`/`i_A_DATA`/`i_RAM_Wr`), in bit-reversed address order. It then asserts the core's START and waits for the core to take and release the RAM (`o_RAM_BLOCK`) before loading the next frame. The FFT B-port is not driven by this block; the top level ties it off.

## Interface
- `IWL`, default 32: sample word width; {re[IWL/2-1:0], im[IWL/2-1:0]}, passed through unmodified.
- `AWL`, default 5: RAM address width; frame length N = 2^AWL.
- `START_LEN`, default 2: number of cycles `o_START` is held high.

Ports:
- `CLK`  in  1  system clock, all logic on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `EN`  in  1  global enable; low freezes all state.
- `i_DATA`  in  IWL  input sample.
- `i_VALID`  in  1  sample valid.
- `o_READY`  out  1  loader can accept a sample.
- `i_FFT_BLOCK`  in  1  from FFT `o_RAM_BLOCK`; high while the core owns the RAM.
- `o_A_ADDR`  out  AWL  RAM write address (to FFT `i_A_ADDR`).
- `o_A_DATA`  out  IWL  RAM write data (to FFT `i_A_DATA`).
- `o_RAM_Wr`  out  1  RAM write strobe (to FFT `i_RAM_Wr`).
- `o_START`  out  1  FFT start (to FFT `START`).
- `o_FRAME_DONE`  out  1  one-cycle pulse when the FFT has released the RAM after a frame.

## Operation
- FSM states: LOAD, START, WAIT_ACK, WAIT_DONE.
- Reset: state LOAD, sample counter `cnt` = 0, START counter = 0, all outputs 0.
- LOAD: `o_READY` = EN & (state==LOAD) & ~i_FFT_BLOCK (combinational). A handshake is `i_VALID & o_READY`. On each handshake, `cnt` increments, and the next cycle drives `o_RAM_Wr`=1, `o_A_ADDR`=addr(cnt), `o_A_DATA`=i_DATA (registered). On the handshake where cnt = N-1: `cnt` wraps to 0 and the state goes to START.
- START: `o_START`=1 for exactly START_LEN enabled cycles, then WAIT_ACK.
- WAIT_ACK: wait for i_FFT_BLOCK=1, then WAIT_DONE. `o_START` is 0 here.
- WAIT_DONE: wait for i_FFT_BLOCK=0. Then pulse `o_FRAME_DONE` for 1 cycle and go to LOAD.
- If i_FFT_BLOCK=1 in LOAD (unexpected): `o_READY`=0, `cnt` is held, and no writes are issued.
- The loader never asserts `o_RAM_Wr` while in START, WAIT_ACK or WAIT_DONE.
- EN=0: the FSM, `cnt` and the START counter freeze, `o_READY`=0, and `o_RAM_Wr`/`o_START`/`o_FRAME_DONE` are forced to 0. A write already registered is held and issued once EN returns to 1.
- RST asserted mid-frame: the partial frame is discarded and the block returns to the reset state immediately (asynchronous). No START is issued.

## Timing
- Handshake at edge k: RAM write is presented in cycle k+1, so latency is 1 cycle. Throughput is 1 sample/cycle.
- Last handshake at edge k: `o_READY` is low from k+1. `o_START` is high during cycles k+1 .. k+START_LEN. The last RAM write (cycle k+1) coincides with the first START cycle; the core samples START after the write commits.
- `o_FRAME_DONE` is asserted in the cycle after i_FFT_BLOCK is sampled low in WAIT_DONE. `o_READY` rises in the same cycle.
- Minimum frame turnaround: N + START_LEN + 2 + (FFT busy time) cycles.

## Configuration
- `FFT_LOADER_BITREV_EN` defined: addr(cnt) = bit-reverse of cnt over AWL bits. This gives natural-order output from the in-place radix-2 core.
- Not defined: addr(cnt) = cnt, natural order. Use this when the core performs its own input reordering.

## Test plan
- Reset, then EN=1, i_VALID held high, AWL=5, BITREV on, i_DATA = index -> 32 writes. cnt=1 writes to addr 16, cnt=3 to addr 24, cnt=31 to addr 31. `o_START` is high for 2 cycles right after the last write.
- Same stimulus with the macro undefined -> addr equals cnt (0..31) and data equals addr on every write.
- i_VALID toggling 1-0-1-0 -> exactly 32 writes with no gaps in address sequence order. START is issued only after the 32nd handshake.
- Drive i_FFT_BLOCK high 3 cycles after START and low 100 cycles later -> no writes and `o_READY`=0 throughout. `o_FRAME_DONE` pulses 1 cycle after the fall, and the next frame loads into addr 0 first.
- Drop EN for 4 cycles at sample 10 -> no writes, `o_READY`=0 during the gap. The frame then resumes at sample 11 with correct addresses.
- Assert RST at sample 20 -> all outputs go to 0 asynchronously and no START is issued. The following 32 samples form a fresh frame starting at cnt=0.
